mac_word_accumulator: RTL and testbench



---
 rtl/mac_word_accumulator.sv | 127 ++++++++++++
 tb/tb_mac_word_accumulator.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_word_accumulator.sv
// Word-serial MAC: feeds A[i]*b to an external multiplier and folds each product plus C[i] into a running carry.
// Latency MUL_LAT+2 from accepted beat to out_valid; no backpressure, one beat per cycle sustained.
module mac_word_accumulator #(
  parameter int W       = 128,
  parameter int MUL_LAT = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic           in_first,
  input  logic           in_last,
  input  logic [W-1:0]   a_word,
  input  logic [W-1:0]   b_word,
  input  logic [W-1:0]   c_word,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_s,
  output logic           out_valid,
  output logic [W-1:0]   out_word,
  output logic           out_last,
  output logic [W-1:0]   out_hi,
  output logic [7:0]     out_idx,
  output logic           seq_err
);

  // Side data sits one register beside mul_a/mul_b, then MUL_LAT more to meet mul_s.
  localparam int DEPTH = MUL_LAT + 1;

  typedef enum logic {S_IDLE, S_ACC} state_t;

  logic [W-1:0]     r_mul_a;
  logic [W-1:0]     r_mul_b;
  logic [DEPTH-1:0] r_vld_sr;
  logic [DEPTH-1:0] r_first_sr;
  logic [DEPTH-1:0] r_last_sr;
  logic [W-1:0]     r_c_sr [DEPTH];

  state_t           r_state;
  logic [W-1:0]     r_carry;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_seq_err;
  logic [W-1:0]     r_out_word;
  logic [W-1:0]     r_out_hi;
  logic [7:0]       r_out_idx;

  logic             w_vld_d;
  logic             w_first_d;
  logic             w_last_d;
  logic [W-1:0]     w_c_d;
  logic             w_as_first;
  logic             w_seq_err;
  logic [2*W-1:0]   w_carry_in;
  logic [2*W-1:0]   w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_vld_sr <= '0;
    end else begin
      if (in_valid) begin
        r_mul_a <= a_word;
        r_mul_b <= b_word;
      end
      r_vld_sr <= {r_vld_sr[DEPTH-2:0], in_valid};
    end
  end

  always_ff @(posedge clk) begin
    r_first_sr <= {r_first_sr[DEPTH-2:0], in_first};
    r_last_sr  <= {r_last_sr[DEPTH-2:0], in_last};
    r_c_sr[0]  <= c_word;
    for (int i = 1; i < DEPTH; i++) begin
      r_c_sr[i] <= r_c_sr[i-1];
    end
  end

  assign w_vld_d   = r_vld_sr[DEPTH-1];
  assign w_first_d = r_first_sr[DEPTH-1];
  assign w_last_d  = r_last_sr[DEPTH-1];
  assign w_c_d     = r_c_sr[DEPTH-1];

  // A beat arriving in IDLE starts a row whether or not it was flagged first.
  assign w_as_first = w_first_d || (r_state == S_IDLE);
  assign w_seq_err  = (r_state == S_ACC) ? w_first_d : !w_first_d;
  assign w_carry_in = w_as_first ? '0 : {{W{1'b0}}, r_carry};
  assign w_sum      = mul_s + {{W{1'b0}}, w_c_d} + w_carry_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_carry     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_seq_err   <= 1'b0;
      r_out_word  <= '0;
      r_out_hi    <= '0;
      r_out_idx   <= '0;
    end else begin
      r_out_valid <= w_vld_d;
      r_out_last  <= w_vld_d && w_last_d;
      r_seq_err   <= w_vld_d && w_seq_err;
      if (w_vld_d) begin
        r_out_word <= w_sum[W-1:0];
        r_out_hi   <= w_last_d ? w_sum[2*W-1:W] : '0;
        r_carry    <= w_last_d ? '0 : w_sum[2*W-1:W];
        r_out_idx  <= w_as_first ? 8'd0 : r_out_idx + 8'd1;
        case (r_state)
          S_IDLE:  r_state <= w_last_d ? S_IDLE : S_ACC;
          S_ACC:   r_state <= w_last_d ? S_IDLE : S_ACC;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign out_last  = r_out_last;
  assign out_hi    = r_out_hi;
  assign out_idx   = r_out_idx;
  assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_mac_word_accumulator.sv
// Bench for mac_word_accumulator: behavioural multiplier, multi-word integer reference model,
// directed rows from the plan plus randomized framing, bubbles and resets.
module tb_mac_word_accumulator;
  localparam int W = 128;
  localparam int L = 6;

  typedef logic [W-1:0] word_t;
  typedef struct {
    word_t       word;
    word_t       hi;
    logic [7:0]  idx;
    logic        last;
    logic        err;
    int unsigned edge_n;
  } rec_t;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_first;
  logic           in_last;
  word_t          a_word;
  word_t          b_word;
  word_t          c_word;
  word_t          mul_a;
  word_t          mul_b;
  logic [2*W-1:0] mul_s;
  logic           out_valid;
  word_t          out_word;
  logic           out_last;
  word_t          out_hi;
  logic [7:0]     out_idx;
  logic           seq_err;

  mac_word_accumulator #(.W(W), .MUL_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .a_word(a_word), .b_word(b_word), .c_word(c_word),
    .mul_a(mul_a), .mul_b(mul_b), .mul_s(mul_s),
    .out_valid(out_valid), .out_word(out_word), .out_last(out_last),
    .out_hi(out_hi), .out_idx(out_idx), .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stand-in: product of the operands seen MUL_LAT edges earlier.
  logic [2*W-1:0] mpipe [L];
  always @(posedge clk) begin
    mpipe[0] <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_s = mpipe[L-1];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  word_t sh_a, sh_b;
  always @(posedge clk) begin
    if (rst) begin
      sh_a <= '0;
      sh_b <= '0;
    end else if (in_valid) begin
      sh_a <= a_word;
      sh_b <= b_word;
    end
  end

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: beats grouped into segments (row start to row end/restart/reset),
  // each segment evaluated as C + A*b over multi-word integers.
  word_t       s_a[$];
  word_t       s_c[$];
  int unsigned s_e[$];
  bit          s_err[$];
  word_t       s_b;
  bit          m_in_row = 0;
  rec_t        exp_q[$];
  rec_t        obs_q[$];

  task automatic close_seg(input bit is_last, input int unsigned cut);
    int             n;
    word_t          p[$];
    word_t          r[$];
    logic [2*W-1:0] t;
    logic [W:0]     s;
    word_t          cy, ci;
    logic           c1;
    rec_t           x;
    n  = s_a.size();
    cy = '0;
    for (int i = 0; i < n; i++) begin
      t = {{W{1'b0}}, s_a[i]} * {{W{1'b0}}, s_b} + {{W{1'b0}}, cy};
      p.push_back(t[W-1:0]);
      cy = t[2*W-1:W];
    end
    p.push_back(cy);
    c1 = 1'b0;
    for (int i = 0; i <= n; i++) begin
      ci = (i < n) ? s_c[i] : '0;
      s  = {1'b0, p[i]} + {1'b0, ci} + {{W{1'b0}}, c1};
      r.push_back(s[W-1:0]);
      c1 = s[W];
    end
    for (int i = 0; i < n; i++) begin
      x.word   = r[i];
      x.last   = is_last && (i == n - 1);
      x.hi     = x.last ? r[n] : '0;
      x.idx    = i[7:0];
      x.err    = s_err[i];
      x.edge_n = s_e[i] + L + 1;
      if (x.edge_n < cut) exp_q.push_back(x);
    end
    s_a.delete(); s_c.delete(); s_e.delete(); s_err.delete();
  endtask

  task automatic model_accept(input logic f, input logic l, input word_t a, input word_t b, input word_t c);
    bit err;
    err = 1'b0;
    if (f || !m_in_row) begin
      err = (f && m_in_row) || (!f && !m_in_row);
      if (m_in_row) close_seg(1'b0, 32'hFFFF_FFFF);
      s_b = b;
    end
    s_a.push_back(a);
    s_c.push_back(c);
    s_e.push_back(cyc + 1);
    s_err.push_back(err);
    if (l) begin
      close_seg(1'b1, 32'hFFFF_FFFF);
      m_in_row = 0;
    end else begin
      m_in_row = 1;
    end
  endtask

  function automatic word_t rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic word_t rnd_op();
    word_t v;
    v = '1;
    if ($urandom_range(0, 3) != 0) v = rnd();
    return v;
  endfunction

  task automatic drive_beat(input logic f, input logic l, input word_t a, input word_t b, input word_t c);
    @(negedge clk);
    in_valid = 1'b1; in_first = f; in_last = l;
    a_word = a; b_word = b; c_word = c;
    model_accept(f, l, a, b, c);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_first = 1'($urandom); in_last = 1'($urandom);
      a_word = rnd(); b_word = rnd(); c_word = rnd();
    end
  endtask

  word_t ra[$];
  word_t rc[$];

  // gap < 0 selects random bubbles inside the row.
  task automatic send_row(input word_t b, input int gap, input int rs_at, input bit no_first);
    int n;
    n = ra.size();
    for (int i = 0; i < n; i++) begin
      drive_beat((i == 0 && !no_first) || i == rs_at, i == n - 1, ra[i], b, rc[i]);
      if (gap > 0) idle(gap);
      else if (gap < 0 && i < n - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic reset_dut();
    int unsigned r;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    r = cyc + 1;
    close_seg(1'b0, r);
    m_in_row = 0;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].edge_n >= r) exp_q.delete(i);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_last",  256'(out_last),  256'(0));
    chk("rst_err",   256'(seq_err),   256'(0));
    chk("rst_word",  256'(out_word),  256'(0));
    chk("rst_hi",    256'(out_hi),    256'(0));
    chk("rst_idx",   256'(out_idx),   256'(0));
    chk("rst_mul_a", 256'(mul_a),     256'(0));
    chk("rst_mul_b", 256'(mul_b),     256'(0));
  endtask

  task automatic expect_out(input string tag, input int maxwait, input word_t w, input word_t hi,
                            input logic [7:0] idx, input logic last, input logic err);
    bit seen;
    seen = 0;
    for (int k = 0; k < maxwait && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk({tag, "_seen"}, 256'(seen), 256'(1));
    if (seen) begin
      chk({tag, "_word"}, 256'(out_word), 256'(w));
      chk({tag, "_hi"},   256'(out_hi),   256'(hi));
      chk({tag, "_idx"},  256'(out_idx),  256'(idx));
      chk({tag, "_last"}, 256'(out_last), 256'(last));
      chk({tag, "_err"},  256'(seq_err),  256'(err));
    end
  endtask

  always @(negedge clk) begin
    rec_t o, x;
    chk("mul_a", 256'(mul_a), 256'(sh_a));
    chk("mul_b", 256'(mul_b), 256'(sh_b));
    if (out_valid) begin
      o.word = out_word; o.hi = out_hi; o.idx = out_idx;
      o.last = out_last; o.err = seq_err; o.edge_n = cyc;
      obs_q.push_back(o);
    end else begin
      chk("stray_flags", 256'({out_last, seq_err}), 256'(0));
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      chk("m_edge", 256'(o.edge_n), 256'(x.edge_n));
      chk("m_word", 256'(o.word),   256'(x.word));
      chk("m_hi",   256'(o.hi),     256'(x.hi));
      chk("m_idx",  256'(o.idx),    256'(x.idx));
      chk("m_last", 256'(o.last),   256'(x.last));
      chk("m_err",  256'(o.err),    256'(x.err));
    end
  end

  initial begin
    word_t ones, ones_m1;
    int unsigned e0;
    ones = '1;
    ones_m1 = ones - 1;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    a_word = '0; b_word = '0; c_word = '0;
    reset_dut();

    // (2^128-1)^2 + (2^128-1) = 2^256 - 2^128
    ra = '{ones}; rc = '{ones};
    send_row(ones, 0, -1, 0); idle(1);
    expect_out("single", 20, '0, ones, 8'd0, 1'b1, 1'b0);

    ra = '{128'd1, 128'd2, 128'd3, 128'd4}; rc = '{128'd0, 128'd0, 128'd0, 128'd0};
    send_row(128'd5, 0, -1, 0); idle(1);
    expect_out("x5_0", 20, 128'd5,  '0, 8'd0, 1'b0, 1'b0);
    expect_out("x5_1", 1,  128'd10, '0, 8'd1, 1'b0, 1'b0);
    expect_out("x5_2", 1,  128'd15, '0, 8'd2, 1'b0, 1'b0);
    expect_out("x5_3", 1,  128'd20, '0, 8'd3, 1'b1, 1'b0);

    // (2^384-1)(2^128-1) = words {1, 2^128-1, 2^128-1}, high word 2^128-2
    for (int g = 0; g < 2; g++) begin
      ra = '{ones, ones, ones}; rc = '{128'd0, 128'd0, 128'd0};
      send_row(ones, g, -1, 0); idle(1);
      expect_out("chain_0", 20,    128'd1, '0,      8'd0, 1'b0, 1'b0);
      expect_out("chain_1", g + 1, ones,   '0,      8'd1, 1'b0, 1'b0);
      expect_out("chain_2", g + 1, ones,   ones_m1, 8'd2, 1'b1, 1'b0);
    end

    ra = '{ones, ones, ones, ones, ones}; rc = '{128'd0, 128'd0, 128'd0, 128'd0, 128'd0};
    send_row(ones, 0, 2, 0); idle(1);
    expect_out("rs_0", 20, 128'd1, '0,      8'd0, 1'b0, 1'b0);
    expect_out("rs_1", 1,  ones,   '0,      8'd1, 1'b0, 1'b0);
    expect_out("rs_2", 1,  128'd1, '0,      8'd0, 1'b0, 1'b1);
    expect_out("rs_3", 1,  ones,   '0,      8'd1, 1'b0, 1'b0);
    expect_out("rs_4", 1,  ones,   ones_m1, 8'd2, 1'b1, 1'b0);

    ra = '{128'd3}; rc = '{128'd5};
    send_row(128'd4, 0, -1, 1); idle(1);
    expect_out("nofirst", 20, 128'd17, '0, 8'd0, 1'b1, 1'b1);

    ra = '{128'd1, 128'd2, 128'd3, 128'd4}; rc = '{128'd0, 128'd0, 128'd0, 128'd0};
    send_row(128'd5, 0, -1, 0);
    e0 = cyc - 2;
    while (cyc + 1 < e0 + L + 2) idle(1);
    reset_dut();
    ra = '{128'd7, 128'd8, 128'd9, 128'd10}; rc = '{128'd1, 128'd1, 128'd1, 128'd1};
    send_row(128'd3, 0, -1, 0); idle(1);
    expect_out("post_0", 20, 128'd22, '0, 8'd0, 1'b0, 1'b0);
    expect_out("post_1", 1,  128'd25, '0, 8'd1, 1'b0, 1'b0);
    expect_out("post_2", 1,  128'd28, '0, 8'd2, 1'b0, 1'b0);
    expect_out("post_3", 1,  128'd31, '0, 8'd3, 1'b1, 1'b0);

    ra.delete(); rc.delete();
    for (int i = 0; i < 258; i++) begin
      ra.push_back(rnd_op());
      rc.push_back(rnd_op());
    end
    send_row(rnd_op(), 0, -1, 0);
    idle(2);

    for (int row = 0; row < 1000; row++) begin
      int n, sel, rs;
      bit nf;
      sel = int'($urandom_range(0, 99));
      n = (sel < 70) ? int'($urandom_range(1, 8)) :
          (sel < 95) ? int'($urandom_range(9, 40)) : int'($urandom_range(200, 256));
      rs = (n > 2 && $urandom_range(0, 29) == 0) ? int'($urandom_range(1, n - 1)) : -1;
      nf = !m_in_row && ($urandom_range(0, 29) == 0);
      ra.delete(); rc.delete();
      for (int i = 0; i < n; i++) begin
        ra.push_back(rnd_op());
        rc.push_back(rnd_op());
      end
      send_row(rnd_op(), -1, rs, nf);
      if ($urandom_range(0, 99) == 0) reset_dut();
      else idle(int'($urandom_range(0, 2)));
    end

    idle(1);
    for (int k = 0; k < 200 && (exp_q.size() > 0 || obs_q.size() > 0); k++) @(negedge clk);
    chk("left_exp", 256'(exp_q.size()), 256'(0));
    chk("left_obs", 256'(obs_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
